// File: rtl/cpu_run_monitor.sv
// Run supervisor for the pipeline_cpu bench: counts RUN cycles/commits, detects halt, hang and timeout,
// and keeps a ring buffer of recent commit PCs. Optional trace: define CPU_RUN_MONITOR_TRACE_EN.
module cpu_run_monitor #(
    parameter int          MAX_CYCLES  = 1000,
    parameter int          STALL_LIMIT = 16,
    parameter int          HIST_DEPTH  = 8,
    parameter logic [31:0] HALT_INSTR  = 32'h0000000C
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          clear,
    input  logic                          commit_valid,
    input  logic [31:0]                   commit_pc,
    input  logic [31:0]                   commit_instr,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_idx,
    output logic [1:0]                    state,
    output logic [1:0]                    fail_code,
    output logic                          done,
    output logic [31:0]                   cycle_count,
    output logic [31:0]                   commit_count,
    output logic [31:0]                   hist_rd_pc,
    output logic [$clog2(HIST_DEPTH):0]   hist_fill
);
    localparam int AW = $clog2(HIST_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10,
        S_FAIL = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  fail_q, fail_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] cmt_q, cmt_d;
    logic [31:0] stall_q, stall_d;
    logic [AW:0] fill_q, fill_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0] hist_q [HIST_DEPTH];
    logic [31:0] hist_d [HIST_DEPTH];
    logic [AW-1:0] rd_ptr;

    always_comb begin
        state_d  = state_q;
        fail_d   = fail_q;
        cyc_d    = cyc_q;
        cmt_d    = cmt_q;
        stall_d  = stall_q;
        fill_d   = fill_q;
        wr_ptr_d = wr_ptr_q;
        hist_d   = hist_q;
        if (clear) begin
            state_d  = S_IDLE;
            fail_d   = 2'b00;
            cyc_d    = '0;
            cmt_d    = '0;
            stall_d  = '0;
            fill_d   = '0;
            wr_ptr_d = '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist_d[i] = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        cyc_d   = '0;
                        cmt_d   = '0;
                        stall_d = '0;
                    end
                end
                S_RUN: begin
                    cyc_d = cyc_q + 32'd1;
                    if (commit_valid) begin
                        cmt_d            = cmt_q + 32'd1;
                        hist_d[wr_ptr_q] = commit_pc;
                        wr_ptr_d         = wr_ptr_q + AW'(1);
                        stall_d          = '0;
                        if (fill_q != (AW+1)'(HIST_DEPTH)) fill_d = fill_q + (AW+1)'(1);
                    end else begin
                        stall_d = stall_q + 32'd1;
                    end
                    // Halt beats hang beats timeout when they land on the same edge.
                    if (commit_valid && commit_instr == HALT_INSTR) begin
                        state_d = S_DONE;
                    end else if (stall_d == 32'(STALL_LIMIT)) begin
                        state_d = S_FAIL;
                        fail_d  = 2'b01;
                    end else if (cyc_d == 32'(MAX_CYCLES)) begin
                        state_d = S_FAIL;
                        fail_d  = 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            fail_q   <= 2'b00;
            cyc_q    <= '0;
            cmt_q    <= '0;
            stall_q  <= '0;
            fill_q   <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            fail_q   <= fail_d;
            cyc_q    <= cyc_d;
            cmt_q    <= cmt_d;
            stall_q  <= stall_d;
            fill_q   <= fill_d;
            wr_ptr_q <= wr_ptr_d;
            hist_q   <= hist_d;
        end
    end

    // Index 0 is the newest entry, so walk backwards from the write pointer.
    assign rd_ptr       = wr_ptr_q - AW'(1) - hist_rd_idx;
    assign hist_rd_pc   = ((AW+1)'(hist_rd_idx) < fill_q) ? hist_q[rd_ptr] : 32'h0;
    assign state        = state_q;
    assign fail_code    = fail_q;
    assign done         = state_q[1];
    assign cycle_count  = cyc_q;
    assign commit_count = cmt_q;
    assign hist_fill    = fill_q;

`ifdef CPU_RUN_MONITOR_TRACE_EN
    logic trace_end_seen;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            trace_end_seen <= 1'b0;
        end else begin
            if (!clear && state_q == S_RUN && commit_valid)
                $display("[run_monitor] cyc=%0d pc=%08h instr=%08h", cyc_q, commit_pc, commit_instr);
            if (state_q[1] && !trace_end_seen) begin
                $display("[run_monitor] end state=%0d fail_code=%0d cycles=%0d commits=%0d",
                         state_q, fail_q, cyc_q, cmt_q);
                for (int i = 0; i < HIST_DEPTH; i++)
                    if ((AW+1)'(i) < fill_q)
                        $display("[run_monitor]   hist[%0d] pc=%08h", i, hist_q[wr_ptr_q - AW'(1) - AW'(i)]);
            end
            trace_end_seen <= state_q[1];
        end
    end
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: vector table for the basic run plus hand sequences for
// hang, timeout, history wrap, halt/timeout collision, async reset and clear/restart.
module tb_cpu_run_monitor;
    logic        clock, reset, start, clear, commit_valid;
    logic [31:0] commit_pc, commit_instr;
    logic [2:0]  hist_rd_idx;
    logic [1:0]  state, fail_code;
    logic        done;
    logic [31:0] cycle_count, commit_count, hist_rd_pc;
    logic [3:0]  hist_fill;

    int checks = 0;
    int errors = 0;

    cpu_run_monitor #(
        .MAX_CYCLES (20),
        .STALL_LIMIT(16),
        .HIST_DEPTH (8),
        .HALT_INSTR (32'h0000000C)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .clear       (clear),
        .commit_valid(commit_valid),
        .commit_pc   (commit_pc),
        .commit_instr(commit_instr),
        .hist_rd_idx (hist_rd_idx),
        .state       (state),
        .fail_code   (fail_code),
        .done        (done),
        .cycle_count (cycle_count),
        .commit_count(commit_count),
        .hist_rd_pc  (hist_rd_pc),
        .hist_fill   (hist_fill)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        st;
        logic        clr;
        logic        cv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  idx;
        logic [1:0]  e_state;
        logic [1:0]  e_fail;
        logic [31:0] e_cyc;
        logic [31:0] e_cmt;
        logic [3:0]  e_fill;
        logic [31:0] e_rdpc;
    } vec_t;

    vec_t vt [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic [1:0] st, input logic [1:0] fc,
                                input logic [31:0] cyc, input logic [31:0] cmt, input logic [3:0] fill);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".fail_code"}, 32'(fail_code), 32'(fc));
        check({tag, ".done"}, 32'(done), 32'(st[1]));
        check({tag, ".cycle_count"}, cycle_count, cyc);
        check({tag, ".commit_count"}, commit_count, cmt);
        check({tag, ".hist_fill"}, 32'(hist_fill), 32'(fill));
    endtask

    task automatic step(input logic s, input logic c, input logic cv,
                        input logic [31:0] pc, input logic [31:0] instr);
        start        = s;
        clear        = c;
        commit_valid = cv;
        commit_pc    = pc;
        commit_instr = instr;
        @(posedge clock);
        #1;
    endtask

    task automatic read_hist(input string name, input logic [2:0] idx, input logic [31:0] exp);
        hist_rd_idx = idx;
        #1;
        check(name, hist_rd_pc, exp);
    endtask

    initial begin
        //           st  clr cv  pc            instr         idx   state  fail   cyc    cmt    fill  rdpc
        vt[0] = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        3'd0, 2'd1, 2'd0, 32'd0, 32'd0, 4'd0, 32'h0};
        vt[1] = '{1'b0, 1'b0, 1'b1, 32'h0,   32'h00000013, 3'd0, 2'd1, 2'd0, 32'd1, 32'd1, 4'd1, 32'h0};
        vt[2] = '{1'b0, 1'b0, 1'b1, 32'h4,   32'h00000013, 3'd0, 2'd1, 2'd0, 32'd2, 32'd2, 4'd2, 32'h4};
        vt[3] = '{1'b0, 1'b0, 1'b1, 32'h8,   32'h00000013, 3'd1, 2'd1, 2'd0, 32'd3, 32'd3, 4'd3, 32'h4};
        vt[4] = '{1'b0, 1'b0, 1'b1, 32'hC,   32'h0000000C, 3'd0, 2'd2, 2'd0, 32'd4, 32'd4, 4'd4, 32'hC};
        vt[5] = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        3'd2, 2'd2, 2'd0, 32'd4, 32'd4, 4'd4, 32'h4};
        vt[6] = '{1'b0, 1'b0, 1'b1, 32'h100, 32'h00000013, 3'd4, 2'd2, 2'd0, 32'd4, 32'd4, 4'd4, 32'h0};
        vt[7] = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        3'd0, 2'd0, 2'd0, 32'd0, 32'd0, 4'd0, 32'h0};
        vt[8] = '{1'b0, 1'b0, 1'b1, 32'h40,  32'h00000013, 3'd0, 2'd0, 2'd0, 32'd0, 32'd0, 4'd0, 32'h0};

        reset = 1'b0; start = 1'b0; clear = 1'b0; commit_valid = 1'b0;
        commit_pc = '0; commit_instr = '0; hist_rd_idx = '0;
        #12;
        check_status("reset", 2'd0, 2'd0, 32'd0, 32'd0, 4'd0);
        check("reset.hist_rd_pc", hist_rd_pc, 32'h0);
        reset = 1'b1;
        @(negedge clock);

        // basic halt run, terminal freeze, clear priority and IDLE commit-ignore
        for (int i = 0; i < 9; i++) begin
            hist_rd_idx = vt[i].idx;
            step(vt[i].st, vt[i].clr, vt[i].cv, vt[i].pc, vt[i].instr);
            check_status($sformatf("vec%0d", i), vt[i].e_state, vt[i].e_fail,
                         vt[i].e_cyc, vt[i].e_cmt, vt[i].e_fill);
            check($sformatf("vec%0d.hist_rd_pc", i), hist_rd_pc, vt[i].e_rdpc);
        end

        // hang: 16 commit-free RUN cycles
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 1; i <= 15; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_status("hang.pre", 2'd1, 2'd0, 32'd15, 32'd0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_status("hang", 2'd3, 2'd1, 32'd16, 32'd0, 4'd0);
        step(1'b1, 1'b0, 1'b1, 32'h0, 32'h0000000C);
        check_status("hang.frozen", 2'd3, 2'd1, 32'd16, 32'd0, 4'd0);

        // timeout: commit every cycle, never halt
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        check_status("clear.fail", 2'd0, 2'd0, 32'd0, 32'd0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int n = 0; n < 19; n++) step(1'b0, 1'b0, 1'b1, 32'(4 * n), 32'h00000013);
        check_status("timeout.pre", 2'd1, 2'd0, 32'd19, 32'd19, 4'd8);
        step(1'b0, 1'b0, 1'b1, 32'(4 * 19), 32'h00000013);
        check_status("timeout", 2'd3, 2'd2, 32'd20, 32'd20, 4'd8);

        // history wrap: 10 commits at pc=4n, start held high throughout, then halt at 0x28
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int n = 0; n < 10; n++) step(1'b1, 1'b0, 1'b1, 32'(4 * n), 32'h00000013);
        step(1'b1, 1'b0, 1'b1, 32'h28, 32'h0000000C);
        check_status("wrap", 2'd2, 2'd0, 32'd11, 32'd11, 4'd8);
        read_hist("wrap.idx0", 3'd0, 32'h28);
        read_hist("wrap.idx1", 3'd1, 32'h24);
        read_hist("wrap.idx7", 3'd7, 32'h0C);

        // halt on the edge that also reaches MAX_CYCLES
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int n = 0; n < 19; n++) step(1'b0, 1'b0, 1'b1, 32'h1000 + 32'(4 * n), 32'h00000013);
        step(1'b0, 1'b0, 1'b1, 32'h2000, 32'h0000000C);
        check_status("halt_vs_timeout", 2'd2, 2'd0, 32'd20, 32'd20, 4'd8);
        read_hist("halt_vs_timeout.idx0", 3'd0, 32'h2000);

        // asynchronous reset mid-run, then a fresh run
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h50, 32'h00000013);
        step(1'b0, 1'b0, 1'b1, 32'h54, 32'h00000013);
        check_status("midrun", 2'd1, 2'd0, 32'd2, 32'd2, 4'd2);
        #2 reset = 1'b0;
        #1;
        hist_rd_idx = 3'd0;
        #1;
        check_status("async_reset", 2'd0, 2'd0, 32'd0, 32'd0, 4'd0);
        check("async_reset.hist_rd_pc", hist_rd_pc, 32'h0);
        reset = 1'b1;
        @(negedge clock);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h60, 32'h00000013);
        check_status("restart", 2'd1, 2'd0, 32'd1, 32'd1, 4'd1);
        read_hist("restart.idx0", 3'd0, 32'h60);
        read_hist("restart.idx1", 3'd1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
- Parametrised, largely synthesizable run supervisor for the pipeline_cpu bench; replaces ad-hoc per-clock printing with a structured monitor.
- Watches the write-back commit stream and counts cycles and commits.
- Detects normal program end, pipeline hang and cycle timeout.
- Keeps a ring buffer of the most recent committed PCs so the bench can dump history on failure.

Parameters:
- MAX_CYCLES, 1000: cycle budget counted in RUN; reaching it ends the run as TIMEOUT.
- STALL_LIMIT, 16: consecutive RUN cycles without a commit that constitute a hang.
- HIST_DEPTH, 8: ring-buffer entries; power of two, minimum 2.
- HALT_INSTR, 32'h0000000C: committed instruction word that marks program end (syscall).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse: IDLE->RUN.
- clear  in  1  synchronous return to IDLE from any state; clears all counters and history.
- commit_valid  in  1  an instruction retires in WB this cycle.
- commit_pc  in  32  PC of the retiring instruction.
- commit_instr  in  32  instruction word of the retiring instruction.
- hist_rd_idx  in  $clog2(HIST_DEPTH)  history read index; 0 = newest.
- state  out  2  00 IDLE, 01 RUN, 10 DONE, 11 FAIL.
- fail_code  out  2  00 none, 01 HANG, 10 TIMEOUT.
- done  out  1  high in DONE or FAIL.
- cycle_count  out  32  cycles spent in RUN.
- commit_count  out  32  commits accepted in RUN.
- hist_rd_pc  out  32  combinational read of history[hist_rd_idx].
- hist_fill  out  $clog2(HIST_DEPTH)+1  valid entries; saturates at HIST_DEPTH.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, fail_code=0, done=0, both counters=0, stall counter=0, hist_fill=0, write pointer=0, all history entries=0.
- IDLE:
  - commits ignored; counters hold.
  - start=1 -> RUN next edge; counters zeroed on that edge.
- RUN, each cycle:
  - cycle_count += 1.
  - On commit_valid: commit_count += 1; commit_pc written at the write pointer; pointer wraps modulo HIST_DEPTH; hist_fill += 1 until saturated; stall counter reset to 0.
  - Otherwise: stall counter += 1.
- Exit conditions, evaluated on the same edge that performs the updates above; priority DONE > HANG > TIMEOUT:
  - DONE: commit_valid and commit_instr == HALT_INSTR. The halt commit itself is counted and recorded.
  - HANG: stall counter reaches STALL_LIMIT, i.e. STALL_LIMIT consecutive non-commit cycles. state=FAIL, fail_code=01.
  - TIMEOUT: cycle_count reaches MAX_CYCLES on this edge. state=FAIL, fail_code=10.
- DONE / FAIL:
  - Terminal: counters, history and fail_code frozen.
  - start ignored; only clear or reset leaves.
  - done=1 in both.
- clear has priority over start and over every RUN update. Effect: IDLE, everything zeroed, same as reset but synchronous.
- Reset asserted mid-run aborts immediately; no partial state survives.
- History read:
  - Index i maps to entry (wr_ptr-1-i) mod HIST_DEPTH.
  - Indices >= hist_fill return 0.
  - Wrap: after HIST_DEPTH+k commits, idx HIST_DEPTH-1 returns commit number k+1 (1-based).
- Counters: 32-bit. MAX_CYCLES must fit in 32 bits; no counter wrap handling is needed.
- start held high for several cycles is equivalent to a single pulse.

Optional Feature:
- Macro: CPU_RUN_MONITOR_TRACE_EN.
- Defined: simulation-only $display on every accepted commit, printing cycle_count, commit_pc and commit_instr. On entry to DONE or FAIL, one summary line with state, fail_code and both counts, then a dump of history newest-first.
- Undefined: no display code compiled; all port behaviour identical.

Test Plan:
- Reset then start; commit pc 0,4,8 on consecutive cycles, then commit_instr=0000000C at pc 0C -> DONE, commit_count=4, hist_rd_idx=0 gives 0000000C, hist_fill=4, fail_code=0.
- start, then no commits for 16 cycles (STALL_LIMIT=16) -> FAIL, fail_code=01 on the 16th edge, cycle_count=16.
- MAX_CYCLES=20, commit every cycle, never halt -> FAIL, fail_code=10, cycle_count=20, commit_count=20.
- HIST_DEPTH=8, 10 commits at pc=4*n (n=0..9), then halt -> idx0 = pc of halt commit, idx1=0x24, idx7=0x0C, hist_fill=8.
- Halt commit on the same edge as stall/timeout threshold -> DONE wins, fail_code=0.
- Reset pulled low for 2 ns mid-RUN -> all outputs zero and IDLE immediately, without waiting for a clock edge. clear in DONE -> IDLE next edge; a subsequent start runs again from zeroed counters.
